sprite_compositor: RTL and testbench
====================================

// Module: sprite_compositor
// PURPOSE
//  Multi-sprite, pipelined colour mapper between the VGA controller and the VGA DAC pins.
//  Per pixel: hit-tests N rectangular sprites, fetches texels from per-sprite synchronous ROMs,
//  drops colour-keyed (transparent) texels, resolves priority, else emits a selectable background.
//  Sprite descriptors are shadowed at frame start, so game logic may update them mid-frame tear-free.
// PARAMETERS
//  N_SPR      2         number of sprite channels (1..8)
//  ADDR_W     13        sprite ROM address width per channel
//  COLOR_W    24        texel width, {R[23:16],G[15:8],B[7:0]}
//  TRANSP_KEY 24'hFF00FF texel value treated as transparent
// PORTS
//  Clk         in   1              system clock (50 MHz)
//  Reset_n     in   1              async active-low reset
//  pix_en      in   1              pixel strobe; pipeline advances only when 1
//  frame_start in   1              1-Clk pulse; latch sprite descriptors into shadow regs
//  DrawX,DrawY in   10 each        current pixel coordinate
//  blank_n     in   1              0 = blanking interval
//  spr_en      in   N_SPR          per-sprite enable
//  spr_x,spr_y in   N_SPR x 10     sprite top-left
//  spr_w,spr_h in   N_SPR x 10     sprite size in pixels (0 = never hit)
//  spr_base    in   N_SPR x ADDR_W ROM base address of sprite image
//  rom_addr    out  N_SPR x ADDR_W registered ROM address, one per channel
//  rom_data    in   N_SPR x COLOR_W ROM data, valid 1 Clk after rom_addr
//  bg_mode     in   2              0 solid, 1 gradient, 2 checker, 3 = solid
//  bg_color    in   COLOR_W        background colour for modes 0/2/3
//  VGA_R,VGA_G,VGA_B out 8 each    registered RGB
//  rgb_valid   out  1              1 when VGA_* correspond to a non-blank pixel
// BEHAVIOUR
//  Reset: shadow descriptors, rom_addr, all pipeline regs, VGA_*, rgb_valid -> 0 (async).
//  Shadow: on frame_start, shadow <= spr_* (regardless of pix_en). A pixel entering S1 in the
//   same cycle uses the OLD shadow; new values apply from the next cycle.
//  S1 (pix_en): hit[i] = shd_en[i] & DrawX>=x & DrawX<x+w & DrawY>=y & DrawY<y+h; compares in
//   11 bits, so x+w > 1023 does not wrap. rom_addr[i] <= base + (DrawY-y)*w + (DrawX-x),
//   truncated mod 2^ADDR_W; held (not updated) on miss. Also registers hit, blank_n, DrawX/Y.
//  S2 (pix_en): eff[i] = hit1[i] & (rom_data[i] != TRANSP_KEY). Winner = lowest index with eff;
//   none -> background. blank1=0 -> RGB 0, rgb_valid 0. Registers VGA_* and rgb_valid.
//  Latency: exactly 2 pix_en strobes from DrawX/DrawY to VGA_*. pix_en=0 holds all state.
//  ROM timing: rom_addr is stable >=1 Clk before the next pix_en, so rom_data is valid at S2.
//  Background (uses pixel's S1 DrawX/Y): mode1 R=8'h3F, G=8'h00, B=8'h7F-{1'b0,X[9:3]};
//   mode2 (X[4]^Y[4]) ? bg_color : 0.
//  Reset mid-frame: output black until 2 strobes after release; shadows empty until frame_start.
// STRUCTURE
//  sprite_pkg: COLOR_W, rgb_t struct {r,g,b}, bg_mode_e enum, spr_desc_t struct
//   {en,x,y,w,h,base}, TRANSP_KEY default.
//  Sub-module sprite_hit_addr: one descriptor -> hit + ROM address (S1 logic), N_SPR instances.
//  Top: shadow regs, S2 priority mux, background generator, output regs.
// TESTING
//  1 Reset_n=0 mid-stream -> VGA_*=0, rgb_valid=0 at once; release with spr_en=0, bg_mode=0,
//    bg_color=24'h123456 -> RGB 12/34/56 two strobes later.
//  2 spr0 x=100,y=50,w=32,h=32,base=0; pixel (100,50) -> rom_addr0=0; (131,81) -> 1023;
//    (132,50) -> miss, background.
//  3 spr0 and spr1 overlap at (200,200): both opaque -> spr0 colour; spr0 texel=FF00FF -> spr1.
//  4 spr x=1010,w=32: DrawX=1023 hit, DrawX=5 miss (no wrap); w=0 never hits.
//  5 frame_start with new spr_x while pix_en=1 -> that pixel uses old x, next pixel new x;
//    spr_x changed without frame_start -> no effect.
//  6 bg_mode=1, DrawX=80 -> B=8'h75; blank_n=0 -> RGB 0, rgb_valid 0; pix_en=0 holds outputs.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite compositor slice.
package sprite_pkg;

    localparam int COLOR_W = 24;
    localparam int COORD_W = 10;
    localparam logic [COLOR_W-1:0] TRANSP_KEY_DEF = 24'hFF00FF;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        BG_SOLID     = 2'd0,
        BG_GRADIENT  = 2'd1,
        BG_CHECKER   = 2'd2,
        BG_SOLID_ALT = 2'd3
    } bg_mode_e;

    // Sprite geometry; the ROM base sits beside it because its width follows ADDR_W.
    typedef struct packed {
        logic               en;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] w;
        logic [COORD_W-1:0] h;
    } spr_desc_t;

    // Blue ramp that darkens every 8 pixels across the line.
    function automatic rgb_t gradient_rgb(input logic [6:0] xCoarse);
        rgb_t c;
        c.r = 8'h3F;
        c.g = 8'h00;
        c.b = 8'h7F - {1'b0, xCoarse};
        return c;
    endfunction

endpackage

// File: rtl/sprite_hit_addr.sv
// First pipeline stage for one sprite channel: hit test and ROM texel address.
module sprite_hit_addr
    import sprite_pkg::*;
#(
    parameter int ADDR_W = 13
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              pix_en_i,
    input  spr_desc_t         desc_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [9:0]        drawX_i,
    input  logic [9:0]        drawY_i,
    output logic              hit_o,
    output logic [ADDR_W-1:0] romAddr_o
);

    logic              hit_d, hit_q;
    logic [ADDR_W-1:0] romAddr_d, romAddr_q;
    logic [9:0]        dx, dy;
    logic [19:0]       rowOfs;

    // Bounds are compared with an extra bit so a sprite hanging past x=1023 never wraps to column 0.
    always_comb begin
        dx     = drawX_i - desc_i.x;
        dy     = drawY_i - desc_i.y;
        rowOfs = {10'd0, dy} * {10'd0, desc_i.w};
        hit_d  = desc_i.en
               & ({1'b0, drawX_i} >= {1'b0, desc_i.x})
               & ({1'b0, drawX_i} <  ({1'b0, desc_i.x} + {1'b0, desc_i.w}))
               & ({1'b0, drawY_i} >= {1'b0, desc_i.y})
               & ({1'b0, drawY_i} <  ({1'b0, desc_i.y} + {1'b0, desc_i.h}));
        romAddr_d = romAddr_q;
        if (hit_d) begin
            romAddr_d = base_i + ADDR_W'(rowOfs) + ADDR_W'(dx);
        end
    end

    // Address is held on a miss so the ROM output stays quiet between sprites.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hit_q     <= 1'b0;
            romAddr_q <= '0;
        end else if (pix_en_i) begin
            hit_q     <= hit_d;
            romAddr_q <= romAddr_d;
        end
    end

    assign hit_o     = hit_q;
    assign romAddr_o = romAddr_q;

endmodule

// File: rtl/sprite_compositor.sv
// Two-stage sprite compositor: shadowed descriptors, per-channel hit/address, priority mux and background.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int                 N_SPR      = 2,
    parameter int                 ADDR_W     = 13,
    parameter logic [COLOR_W-1:0] TRANSP_KEY = TRANSP_KEY_DEF
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       pix_en,
    input  logic                       frame_start,
    input  logic [9:0]                 DrawX,
    input  logic [9:0]                 DrawY,
    input  logic                       blank_n,
    input  logic [N_SPR-1:0]           spr_en,
    input  logic [N_SPR*10-1:0]        spr_x,
    input  logic [N_SPR*10-1:0]        spr_y,
    input  logic [N_SPR*10-1:0]        spr_w,
    input  logic [N_SPR*10-1:0]        spr_h,
    input  logic [N_SPR*ADDR_W-1:0]    spr_base,
    output logic [N_SPR*ADDR_W-1:0]    rom_addr,
    input  logic [N_SPR*COLOR_W-1:0]   rom_data,
    input  logic [1:0]                 bg_mode,
    input  logic [COLOR_W-1:0]         bg_color,
    output logic [7:0]                 VGA_R,
    output logic [7:0]                 VGA_G,
    output logic [7:0]                 VGA_B,
    output logic                       rgb_valid
);

    logic [N_SPR-1:0] hit1;
    logic             blank1_q;
    logic [6:0]       xCoarse1_q;
    logic             yBit4_1_q;
    rgb_t             bgRgb, pix_d, pix_q;
    logic             valid_d, valid_q;

    for (genvar i = 0; i < N_SPR; i++) begin : g_chan
        spr_desc_t         shdDesc_q;
        logic [ADDR_W-1:0] shdBase_q;

        // Descriptors are captured only at frame start so mid-frame updates cannot tear the image.
        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                shdDesc_q <= '0;
                shdBase_q <= '0;
            end else if (frame_start) begin
                shdDesc_q.en <= spr_en[i];
                shdDesc_q.x  <= spr_x[i*10 +: 10];
                shdDesc_q.y  <= spr_y[i*10 +: 10];
                shdDesc_q.w  <= spr_w[i*10 +: 10];
                shdDesc_q.h  <= spr_h[i*10 +: 10];
                shdBase_q    <= spr_base[i*ADDR_W +: ADDR_W];
            end
        end

        sprite_hit_addr #(.ADDR_W(ADDR_W)) u_hit (
            .Clk       (Clk),
            .Reset_n   (Reset_n),
            .pix_en_i  (pix_en),
            .desc_i    (shdDesc_q),
            .base_i    (shdBase_q),
            .drawX_i   (DrawX),
            .drawY_i   (DrawY),
            .hit_o     (hit1[i]),
            .romAddr_o (rom_addr[i*ADDR_W +: ADDR_W])
        );
    end

    // Stage-1 side info: blanking plus just the coordinate bits the background needs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            blank1_q   <= 1'b0;
            xCoarse1_q <= '0;
            yBit4_1_q  <= 1'b0;
        end else if (pix_en) begin
            blank1_q   <= blank_n;
            xCoarse1_q <= DrawX[9:3];
            yBit4_1_q  <= DrawY[4];
        end
    end

    // Background generator driven by the pixel that is now in stage 2.
    always_comb begin
        bgRgb = rgb_t'(bg_color);
        unique case (bg_mode_e'(bg_mode))
            BG_GRADIENT: bgRgb = gradient_rgb(xCoarse1_q);
            BG_CHECKER:  bgRgb = (xCoarse1_q[1] ^ yBit4_1_q) ? rgb_t'(bg_color) : '0;
            default:     bgRgb = rgb_t'(bg_color);
        endcase
    end

    // Priority mux: walking downwards lets the lowest opaque channel win.
    always_comb begin
        pix_d   = bgRgb;
        valid_d = blank1_q;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            if (hit1[i] && (rom_data[i*COLOR_W +: COLOR_W] != TRANSP_KEY)) begin
                pix_d = rgb_t'(rom_data[i*COLOR_W +: COLOR_W]);
            end
        end
        if (!blank1_q) begin
            pix_d = '0;
        end
    end

    // Output registers feeding the DAC pins.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pix_q   <= '0;
            valid_q <= 1'b0;
        end else if (pix_en) begin
            pix_q   <= pix_d;
            valid_q <= valid_d;
        end
    end

    assign VGA_R     = pix_q.r;
    assign VGA_G     = pix_q.g;
    assign VGA_B     = pix_q.b;
    assign rgb_valid = valid_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed and randomized checks of sprite_compositor against a pixel-level reference model.
module tb_sprite_compositor;

   localparam logic [23:0] KEY = 24'hFF00FF;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        pix_en = 1'b0;
   logic        frame_start = 1'b0;
   logic [9:0]  DrawX = '0, DrawY = '0;
   logic        blank_n = 1'b1;
   logic [1:0]  tbEn = '0;
   logic [9:0]  tbX [2], tbY [2], tbW [2], tbH [2];
   logic [12:0] tbBase [2];
   logic [19:0] spr_x, spr_y, spr_w, spr_h;
   logic [25:0] spr_base, rom_addr;
   logic [47:0] rom_data;
   logic [1:0]  bg_mode = 2'd0;
   logic [23:0] bg_color = 24'h0;
   logic [7:0]  VGA_R, VGA_G, VGA_B;
   logic        rgb_valid;

   logic [23:0] romMem [2][8192];
   logic [23:0] romQ [2];

   int vectors = 0;
   int miscompares = 0;

   // Reference model state: descriptors as the design should currently see them.
   int mEn [2], mX [2], mY [2], mW [2], mH [2], mBase [2];
   int mAddr [2];
   bit pBlankN, pSpr;
   logic [23:0] pTex;
   int pX, pY;

   assign spr_x    = {tbX[1], tbX[0]};
   assign spr_y    = {tbY[1], tbY[0]};
   assign spr_w    = {tbW[1], tbW[0]};
   assign spr_h    = {tbH[1], tbH[0]};
   assign spr_base = {tbBase[1], tbBase[0]};
   assign rom_data = {romQ[1], romQ[0]};

   always #10 Clk = ~Clk;

   // External synchronous sprite ROMs, one clock of read latency.
   always @(posedge Clk) begin
      romQ[0] <= romMem[0][rom_addr[12:0]];
      romQ[1] <= romMem[1][rom_addr[25:13]];
   end

   sprite_compositor #(.N_SPR(2), .ADDR_W(13), .TRANSP_KEY(KEY)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .pix_en(pix_en), .frame_start(frame_start),
      .DrawX(DrawX), .DrawY(DrawY), .blank_n(blank_n), .spr_en(tbEn),
      .spr_x(spr_x), .spr_y(spr_y), .spr_w(spr_w), .spr_h(spr_h), .spr_base(spr_base),
      .rom_addr(rom_addr), .rom_data(rom_data), .bg_mode(bg_mode), .bg_color(bg_color),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .rgb_valid(rgb_valid)
   );

   function automatic logic [23:0] bgModel(input int px, input int py);
      case (bg_mode)
         2'd1:    return {8'h3F, 8'h00, 8'(127 - px / 8)};
         2'd2:    return (((px / 16) ^ (py / 16)) & 1) != 0 ? bg_color : 24'h0;
         default: return bg_color;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [23:0] expRgb, input logic expValid);
      vectors++;
      assert ({VGA_R, VGA_G, VGA_B} === expRgb) else begin
         miscompares++;
         $error("[TB] FAIL %s rgb observed=%h expected=%h", tag, {VGA_R, VGA_G, VGA_B}, expRgb);
      end
      vectors++;
      assert (rgb_valid === expValid) else begin
         miscompares++;
         $error("[TB] FAIL %s rgb_valid observed=%b expected=%b", tag, rgb_valid, expValid);
      end
   endtask

   task automatic checkAddr(input string tag, input int ch, input int expAddr);
      logic [12:0] obs;
      obs = (ch == 0) ? rom_addr[12:0] : rom_addr[25:13];
      vectors++;
      assert (obs === 13'(expAddr)) else begin
         miscompares++;
         $error("[TB] FAIL %s rom_addr%0d observed=%0d expected=%0d", tag, ch, obs, expAddr);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < 2; i++) begin
         mEn[i] = 0; mX[i] = 0; mY[i] = 0; mW[i] = 0; mH[i] = 0; mBase[i] = 0; mAddr[i] = 0;
      end
      pBlankN = 1'b0; pSpr = 1'b0; pTex = '0; pX = 0; pY = 0;
   endtask

   task automatic modelLatch();
      for (int i = 0; i < 2; i++) begin
         mEn[i] = int'(tbEn[i]); mX[i] = int'(tbX[i]); mY[i] = int'(tbY[i]);
         mW[i] = int'(tbW[i]); mH[i] = int'(tbH[i]); mBase[i] = int'(tbBase[i]);
      end
   endtask

   // One pixel strobe followed by one idle clock (ROM read slot); checks the previous pixel's result.
   task automatic applyStimulus(input string tag, input int x, input int y, input bit bl, input bit fs);
      bit nSpr;
      logic [23:0] nTex, expRgb;
      int a;
      nSpr = 1'b0;
      nTex = '0;
      for (int i = 1; i >= 0; i--) begin
         if (mEn[i] != 0 && x >= mX[i] && x < mX[i] + mW[i] && y >= mY[i] && y < mY[i] + mH[i]) begin
            a = (mBase[i] + (y - mY[i]) * mW[i] + (x - mX[i])) % 8192;
            mAddr[i] = a;
            if (romMem[i][a] != KEY) begin
               nSpr = 1'b1;
               nTex = romMem[i][a];
            end
         end
      end
      DrawX = 10'(x); DrawY = 10'(y); blank_n = bl; frame_start = fs; pix_en = 1'b1;
      @(posedge Clk); #1;
      pix_en = 1'b0; frame_start = 1'b0;
      if (!pBlankN) expRgb = 24'h0;
      else if (pSpr) expRgb = pTex;
      else expRgb = bgModel(pX, pY);
      checkOutput(tag, expRgb, pBlankN);
      checkAddr(tag, 0, mAddr[0]);
      checkAddr(tag, 1, mAddr[1]);
      pBlankN = bl; pSpr = nSpr; pTex = nTex; pX = x; pY = y;
      if (fs) modelLatch();
      @(posedge Clk); #1;
   endtask

   task automatic frameStart();
      frame_start = 1'b1;
      @(posedge Clk); #1;
      frame_start = 1'b0;
      modelLatch();
   endtask

   task automatic setSpr(input int i, input bit en, input int x, input int y, input int w, input int h, input int b);
      tbEn[i] = en; tbX[i] = 10'(x); tbY[i] = 10'(y); tbW[i] = 10'(w); tbH[i] = 10'(h); tbBase[i] = 13'(b);
   endtask

   initial begin
      logic [23:0] v;
      logic [23:0] held;
      int rx, ry, s;
      for (int c = 0; c < 2; c++) begin
         for (int a = 0; a < 8192; a++) begin
            v = 24'($urandom);
            if ($urandom_range(0, 3) == 0) v = KEY;
            romMem[c][a] = v;
         end
      end
      setSpr(0, 0, 0, 0, 0, 0, 0);
      setSpr(1, 0, 0, 0, 0, 0, 0);
      modelReset();

      // Power-on reset state
      #3;
      checkOutput("por", 24'h0, 1'b0);
      checkAddr("por", 0, 0);
      @(negedge Clk); Reset_n = 1'b1;
      @(posedge Clk); #1;
      bg_color = 24'hABCDEF;
      for (int k = 0; k < 3; k++) applyStimulus("warm", 20 + k, 30, 1'b1, 1'b0);

      // 1: reset mid-stream, then solid background two strobes later
      Reset_n = 1'b0;
      #1;
      checkOutput("rst_mid", 24'h0, 1'b0);
      checkAddr("rst_mid", 0, 0);
      modelReset();
      @(negedge Clk); Reset_n = 1'b1;
      @(posedge Clk); #1;
      bg_mode = 2'd0; bg_color = 24'h123456;
      applyStimulus("rst_rel1", 10, 10, 1'b1, 1'b0);
      applyStimulus("rst_rel2", 11, 10, 1'b1, 1'b0);
      vectors++;
      assert ({VGA_R, VGA_G, VGA_B} === 24'h123456) else begin
         miscompares++;
         $error("[TB] FAIL rst_solid observed=%h expected=%h", {VGA_R, VGA_G, VGA_B}, 24'h123456);
      end

      // 2: single sprite address generation and miss
      setSpr(0, 1, 100, 50, 32, 32, 0);
      romMem[0][0] = 24'hA1B2C3; romMem[0][1023] = 24'h0C0D0E;
      frameStart();
      applyStimulus("t2_tl", 100, 50, 1'b1, 1'b0);
      checkAddr("t2_addr_tl", 0, 0);
      applyStimulus("t2_br", 131, 81, 1'b1, 1'b0);
      checkAddr("t2_addr_br", 0, 1023);
      applyStimulus("t2_miss", 132, 50, 1'b1, 1'b0);
      applyStimulus("t2_flush", 0, 0, 1'b1, 1'b0);

      // 3: overlap priority and transparency fall-through
      setSpr(0, 1, 195, 195, 16, 16, 0);
      setSpr(1, 1, 190, 190, 20, 20, 100);
      romMem[0][85] = 24'h112233; romMem[1][310] = 24'h445566;
      frameStart();
      applyStimulus("t3_both", 200, 200, 1'b1, 1'b0);
      applyStimulus("t3_flushA", 0, 0, 1'b1, 1'b0);
      vectors++;
      assert ({VGA_R, VGA_G, VGA_B} === 24'h112233) else begin
         miscompares++;
         $error("[TB] FAIL t3_prio observed=%h expected=%h", {VGA_R, VGA_G, VGA_B}, 24'h112233);
      end
      romMem[0][85] = KEY;
      applyStimulus("t3_key", 200, 200, 1'b1, 1'b0);
      applyStimulus("t3_flushB", 0, 0, 1'b1, 1'b0);
      vectors++;
      assert ({VGA_R, VGA_G, VGA_B} === 24'h445566) else begin
         miscompares++;
         $error("[TB] FAIL t3_transp observed=%h expected=%h", {VGA_R, VGA_G, VGA_B}, 24'h445566);
      end

      // 4: right-edge no-wrap and zero-width sprite
      setSpr(0, 1, 1010, 0, 32, 480, 0);
      setSpr(1, 1, 0, 0, 0, 100, 0);
      romMem[0][173] = 24'h5A5A5A;
      bg_color = 24'h010203;
      frameStart();
      applyStimulus("t4_edge", 1023, 5, 1'b1, 1'b0);
      checkAddr("t4_addr", 0, 173);
      applyStimulus("t4_nowrap", 5, 5, 1'b1, 1'b0);
      applyStimulus("t4_w0", 0, 0, 1'b1, 1'b0);
      applyStimulus("t4_flush", 600, 400, 1'b1, 1'b0);

      // 5: shadow timing of frame_start
      setSpr(0, 1, 300, 300, 10, 10, 2000);
      setSpr(1, 0, 0, 0, 0, 0, 0);
      romMem[0][2005] = 24'h0A0B0C;
      frameStart();
      tbX[0] = 10'd400;
      applyStimulus("t5_oldx", 305, 300, 1'b1, 1'b1);
      applyStimulus("t5_newx", 305, 300, 1'b1, 1'b0);
      applyStimulus("t5_newhit", 405, 300, 1'b1, 1'b0);
      tbX[0] = 10'd500;
      applyStimulus("t5_nolatch", 405, 300, 1'b1, 1'b0);
      applyStimulus("t5_flush", 0, 0, 1'b1, 1'b0);

      // 6: gradient, blanking, and pix_en hold
      tbEn = '0;
      frameStart();
      bg_mode = 2'd1;
      applyStimulus("t6_grad", 80, 10, 1'b1, 1'b0);
      applyStimulus("t6_blank", 81, 10, 1'b0, 1'b0);
      vectors++;
      assert (VGA_B === 8'h75) else begin
         miscompares++;
         $error("[TB] FAIL t6_gradB observed=%h expected=%h", VGA_B, 8'h75);
      end
      applyStimulus("t6_after", 82, 10, 1'b1, 1'b0);
      held = {VGA_R, VGA_G, VGA_B};
      for (int k = 0; k < 6; k++) begin
         DrawX = 10'(k * 37); blank_n = k[0]; bg_mode = 2'(k); bg_color = 24'($urandom);
         @(posedge Clk); #1;
      end
      bg_mode = 2'd1;
      vectors++;
      assert ({VGA_R, VGA_G, VGA_B} === held && rgb_valid === 1'b0) else begin
         miscompares++;
         $error("[TB] FAIL t6_hold observed=%h/%b expected=%h/0", {VGA_R, VGA_G, VGA_B}, rgb_valid, held);
      end
      applyStimulus("t6_resume", 0, 0, 1'b1, 1'b0);

      // Randomized pixels and descriptors against the reference model
      for (int n = 0; n < 240; n++) begin
         if (n % 40 == 0) begin
            for (int i = 0; i < 2; i++)
               setSpr(i, ($urandom_range(0, 4) != 0), $urandom_range(0, 1023), $urandom_range(0, 1023),
                      $urandom_range(0, 80), $urandom_range(0, 80), $urandom_range(0, 8191));
            if ($urandom_range(0, 1) == 0) frameStart();
         end
         bg_mode = 2'($urandom_range(0, 3));
         bg_color = 24'($urandom);
         s = $urandom_range(0, 2);
         if (s == 2) begin
            rx = $urandom_range(0, 1023); ry = $urandom_range(0, 1023);
         end else begin
            rx = (mX[s] + $urandom_range(0, 90)) % 1024;
            ry = (mY[s] + $urandom_range(0, 90)) % 1024;
         end
         applyStimulus("rand", rx, ry, ($urandom_range(0, 7) != 0), (n % 40 == 20));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
